// File: rtl/alu_slice_chain.sv
// rtl/alu_slice_chain.sv - chained 4-bit-slice 16-function ALU evaluated group by group
module alu_slice_chain #(
  parameter int WIDTH            = 36,
  parameter int SLICES_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [0:3]       S,
  input  logic             M,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic             CIN,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] F,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int NSLICE = WIDTH / 4;
  localparam int GW     = 4 * SLICES_PER_CYCLE;
  localparam int NGROUP = (NSLICE + SLICES_PER_CYCLE - 1) / SLICES_PER_CYCLE;
  localparam int PW     = NGROUP * GW;
  // Position of the real MSB inside the last (possibly partial) group.
  localparam int P      = WIDTH - 1 - (NGROUP - 1) * GW;
  localparam int CW     = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NGROUP - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_x;
  logic [PW-1:0]   r_y;
  logic [PW-1:0]   r_acc;
  logic            r_carry;
  logic            r_logic;
  logic [CW-1:0]   r_grp;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_s;
  logic [WIDTH-1:0] w_ones;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [GW-1:0]    w_xg;
  logic [GW-1:0]    w_yg;
  logic [GW:0]      w_sum;
  logic [PW-1:0]    w_acc_next;
  logic             w_cout;
  logic             w_cin_msb;

  assign w_a    = A;
  assign w_b    = B;
  assign w_s    = S;
  assign w_ones = '1;

  // Operand conditioning: logic mode folds the whole function into X with Y=0,
  // so the same add chain streams either kind of result out group by group.
  always_comb begin
    w_x = '0;
    w_y = '0;
    if (M) begin
      unique case (w_s)
        4'h0: w_x = ~w_a;
        4'h1: w_x = ~w_a | ~w_b;
        4'h2: w_x = ~w_a | w_b;
        4'h3: w_x = w_ones;
        4'h4: w_x = ~w_a & ~w_b;
        4'h5: w_x = ~w_b;
        4'h6: w_x = ~(w_a ^ w_b);
        4'h7: w_x = w_a | ~w_b;
        4'h8: w_x = ~w_a & w_b;
        4'h9: w_x = w_a ^ w_b;
        4'hA: w_x = w_b;
        4'hB: w_x = w_a | w_b;
        4'hC: w_x = '0;
        4'hD: w_x = w_a & ~w_b;
        4'hE: w_x = w_a & w_b;
        default: w_x = w_a;
      endcase
    end else begin
      unique case (w_s)
        4'h0: begin w_x = w_a;          w_y = '0;           end
        4'h1: begin w_x = w_a;          w_y = w_a & ~w_b;   end
        4'h2: begin w_x = w_a;          w_y = w_a & w_b;    end
        4'h3: begin w_x = w_a;          w_y = w_a;          end
        4'h4: begin w_x = w_a | w_b;    w_y = '0;           end
        4'h5: begin w_x = w_a | w_b;    w_y = w_a & ~w_b;   end
        4'h6: begin w_x = w_a;          w_y = w_b;          end
        4'h7: begin w_x = w_a | w_b;    w_y = w_a;          end
        4'h8: begin w_x = w_a | ~w_b;   w_y = '0;           end
        4'h9: begin w_x = w_a;          w_y = ~w_b;         end
        4'hA: begin w_x = w_a | ~w_b;   w_y = w_a & w_b;    end
        4'hB: begin w_x = w_a | ~w_b;   w_y = w_a;          end
        4'hC: begin w_x = w_ones;       w_y = '0;           end
        4'hD: begin w_x = w_a & ~w_b;   w_y = w_ones;       end
        4'hE: begin w_x = w_a & w_b;    w_y = w_ones;       end
        default: begin w_x = w_a;       w_y = w_ones;       end
      endcase
    end
  end

  // Current group adder; operands are shifted so the active group is always at the bottom.
  always_comb begin
    w_xg       = r_x[GW-1:0];
    w_yg       = r_y[GW-1:0];
    w_sum      = {1'b0, w_xg} + {1'b0, w_yg} + {{GW{1'b0}}, r_carry};
    w_acc_next = (r_acc >> GW) | (PW'(w_sum[GW-1:0]) << (PW - GW));
    // Padding above the real MSB is zero, so its carry lands at P+1 and stops.
    w_cout     = w_sum[P+1];
    w_cin_msb  = w_xg[P] ^ w_yg[P] ^ w_sum[P];
  end

  // Control FSM plus datapath: latch on start, one group per RUN cycle, publish on the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_logic <= 1'b0;
      r_grp   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      F       <= '0;
      COUT    <= 1'b0;
      OVF     <= 1'b0;
      ZERO    <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_x     <= PW'(w_x);
            r_y     <= PW'(w_y);
            r_carry <= M ? 1'b0 : CIN;
            r_logic <= M;
            r_grp   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_acc   <= w_acc_next;
          r_x     <= r_x >> GW;
          r_y     <= r_y >> GW;
          r_carry <= w_sum[GW];
          r_grp   <= r_grp + CW'(1);
          if (r_grp == LAST) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            F       <= w_acc_next[WIDTH-1:0];
            ZERO    <= (w_acc_next[WIDTH-1:0] == '0);
            COUT    <= r_logic ? 1'b0 : w_cout;
            OVF     <= r_logic ? 1'b0 : (w_cout ^ w_cin_msb);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_chain.sv
// tb/tb_alu_slice_chain.sv - randomized and directed checks of alu_slice_chain against a behavioural model
module tb_alu_slice_chain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  s_in = '0;
  logic        m_in = 1'b0;
  logic [35:0] a_in = '0;
  logic [35:0] b_in = '0;
  logic        cin_in = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DUT instances: three SPC variants at 36 bits and a single 4-bit slice.
  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic [35:0] f0, f1, f2;
  logic [3:0]  f3;
  logic        c0, c1, c2, c3, o0, o1, o2, o3, z0, z1, z2, z3;

  alu_slice_chain #(.WIDTH(36), .SLICES_PER_CYCLE(1)) u_d0 (
    .clk(clk), .reset(reset), .start(start), .S(s_in), .M(m_in), .A(a_in), .B(b_in),
    .CIN(cin_in), .busy(busy0), .done(done0), .F(f0), .COUT(c0), .OVF(o0), .ZERO(z0));
  alu_slice_chain #(.WIDTH(36), .SLICES_PER_CYCLE(2)) u_d1 (
    .clk(clk), .reset(reset), .start(start), .S(s_in), .M(m_in), .A(a_in), .B(b_in),
    .CIN(cin_in), .busy(busy1), .done(done1), .F(f1), .COUT(c1), .OVF(o1), .ZERO(z1));
  alu_slice_chain #(.WIDTH(36), .SLICES_PER_CYCLE(9)) u_d2 (
    .clk(clk), .reset(reset), .start(start), .S(s_in), .M(m_in), .A(a_in), .B(b_in),
    .CIN(cin_in), .busy(busy2), .done(done2), .F(f2), .COUT(c2), .OVF(o2), .ZERO(z2));
  alu_slice_chain #(.WIDTH(4), .SLICES_PER_CYCLE(1)) u_d3 (
    .clk(clk), .reset(reset), .start(start), .S(s_in), .M(m_in), .A(a_in[3:0]), .B(b_in[3:0]),
    .CIN(cin_in), .busy(busy3), .done(done3), .F(f3), .COUT(c3), .OVF(o3), .ZERO(z3));

  logic [35:0] act_f [4];
  logic [3:0]  act_b, act_d, act_c, act_o, act_z;
  assign act_f[0] = f0;
  assign act_f[1] = f1;
  assign act_f[2] = f2;
  assign act_f[3] = {32'b0, f3};
  assign act_b = {busy3, busy2, busy1, busy0};
  assign act_d = {done3, done2, done1, done0};
  assign act_c = {c3, c2, c1, c0};
  assign act_o = {o3, o2, o1, o0};
  assign act_z = {z3, z2, z1, z0};

  int lat [4] = '{9, 5, 1, 1};
  int wid [4] = '{36, 36, 36, 4};

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Behavioural ALU: plain arithmetic over the function tables.
  function automatic logic [63:0] ref_alu(input int w, input logic [3:0] s, input logic m,
                                          input logic [35:0] ai, input logic [35:0] bi,
                                          input logic ci, output logic co, output logic ov);
    logic [63:0] mask, a, b, na, nb, x, y, sum, low, half, f;
    mask = (64'd1 << w) - 64'd1;
    half = mask >> 1;
    a = {28'b0, ai} & mask;
    b = {28'b0, bi} & mask;
    na = ~a & mask;
    nb = ~b & mask;
    co = 1'b0;
    ov = 1'b0;
    x = '0;
    y = '0;
    if (m) begin
      case (s)
        4'h0: f = na;             4'h1: f = na | nb;
        4'h2: f = na | b;         4'h3: f = mask;
        4'h4: f = na & nb;        4'h5: f = nb;
        4'h6: f = ~(a ^ b) & mask; 4'h7: f = a | nb;
        4'h8: f = na & b;         4'h9: f = a ^ b;
        4'hA: f = b;              4'hB: f = a | b;
        4'hC: f = 64'd0;          4'hD: f = a & nb;
        4'hE: f = a & b;          default: f = a;
      endcase
      return f;
    end
    case (s)
      4'h0: begin x = a;      y = 0;      end
      4'h1: begin x = a;      y = a & nb; end
      4'h2: begin x = a;      y = a & b;  end
      4'h3: begin x = a;      y = a;      end
      4'h4: begin x = a | b;  y = 0;      end
      4'h5: begin x = a | b;  y = a & nb; end
      4'h6: begin x = a;      y = b;      end
      4'h7: begin x = a | b;  y = a;      end
      4'h8: begin x = a | nb; y = 0;      end
      4'h9: begin x = a;      y = nb;     end
      4'hA: begin x = a | nb; y = a & b;  end
      4'hB: begin x = a | nb; y = a;      end
      4'hC: begin x = mask;   y = 0;      end
      4'hD: begin x = a & nb; y = mask;   end
      4'hE: begin x = a & b;  y = mask;   end
      default: begin x = a;   y = mask;   end
    endcase
    sum = x + y + {63'b0, ci};
    f = sum & mask;
    co = sum[w];
    low = (x & half) + (y & half) + {63'b0, ci};
    ov = low[w-1] ^ co;
    return f;
  endfunction

  // Expected per-DUT outputs, advanced at each clock from the sampled inputs.
  int          cnt [4];
  logic [35:0] ef [4], pf [4];
  logic        ec [4], eo [4], ed [4], pc [4], po [4];
  bit          model_ok = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        cnt[k] = 0; ef[k] = '0; ec[k] = 0; eo[k] = 0; ed[k] = 0;
      end else if (cnt[k] == 0) begin
        ed[k] = 0;
        if (start) begin
          logic co, ov;
          logic [63:0] r;
          r = ref_alu(wid[k], s_in, m_in, a_in, b_in, cin_in, co, ov);
          pf[k] = r[35:0]; pc[k] = co; po[k] = ov;
          cnt[k] = lat[k];
        end
      end else begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin
          ed[k] = 1; ef[k] = pf[k]; ec[k] = pc[k]; eo[k] = po[k];
        end
      end
    end
    model_ok = 1;
  end

  // Compare every DUT output against the model on every cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 4; k++) begin
        chk("busy", k, {63'b0, act_b[k]}, {63'b0, cnt[k] != 0});
        chk("done", k, {63'b0, act_d[k]}, {63'b0, ed[k]});
        chk("F",    k, {28'b0, act_f[k]}, {28'b0, ef[k]});
        chk("COUT", k, {63'b0, act_c[k]}, {63'b0, ec[k]});
        chk("OVF",  k, {63'b0, act_o[k]}, {63'b0, eo[k]});
        chk("ZERO", k, {63'b0, act_z[k]}, {63'b0, ef[k] == '0});
      end
    end
  end

  task automatic op(input logic [3:0] s, input logic m, input logic [35:0] a,
                    input logic [35:0] b, input logic ci);
    s_in = s; m_in = m; a_in = a; b_in = b; cin_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic co, ov;
    logic [63:0] r;
    int n;
    bit seen;

    r = ref_alu(4, 4'h9, 1'b0, 36'd7, 36'd3, 1'b1, co, ov);
    chk("model_w4_sub", 0, {r[61:0], co, ov}, {62'd4, 1'b1, 1'b0});
    r = ref_alu(36, 4'h0, 1'b0, 36'o377777777777, 36'd0, 1'b1, co, ov);
    chk("model_ovf", 0, {r[61:0], co, ov}, {62'o400000000000, 1'b0, 1'b1});
    r = ref_alu(36, 4'h9, 1'b1, 36'o525252525252, 36'o777777000000, 1'b0, co, ov);
    chk("model_xor", 0, {r[61:0], co, ov}, {62'o252525525252, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_F", 0, {28'b0, f0}, 64'd0);
    chk("rst_ZERO", 0, {63'b0, z0}, 64'd1);
    chk("rst_busy", 0, {63'b0, busy0}, 64'd0);
    @(posedge clk); #1;

    // 4-bit slice: done one cycle after start is sampled.
    op(4'h9, 1'b0, 36'd7, 36'd3, 1'b1);
    @(negedge clk);
    chk("w4_done_early", 3, {63'b0, done3}, 64'd0);
    @(negedge clk);
    chk("w4_done", 3, {63'b0, done3}, 64'd1);
    chk("w4_F", 3, {60'b0, f3}, 64'd4);
    chk("w4_COUT", 3, {63'b0, c3}, 64'd1);
    chk("w4_OVF", 3, {63'b0, o3}, 64'd0);
    repeat (10) @(posedge clk); #1;

    // All-ones plus one: busy exactly 9 cycles on the SPC=1 variant.
    op(4'h0, 1'b0, 36'hFFFFFFFFF, 36'd0, 1'b1);
    n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy0) n++;
      if (done0) seen = 1;
    end
    chk("inc_done_seen", 0, {63'b0, seen}, 64'd1);
    chk("inc_busy_cycles", 0, 64'(n), 64'd9);
    chk("inc_F", 0, {28'b0, f0}, 64'd0);
    chk("inc_COUT", 0, {63'b0, c0}, 64'd1);
    chk("inc_ZERO", 0, {63'b0, z0}, 64'd1);
    chk("inc_F_spc9", 2, {28'b0, f2}, 64'd0);
    @(posedge clk); #1;

    op(4'h0, 1'b0, 36'o377777777777, 36'd0, 1'b1);
    repeat (11) @(posedge clk); #1;
    chk("ovf_F", 0, {28'b0, f0}, 64'o400000000000);
    chk("ovf_OVF", 0, {63'b0, o0}, 64'd1);
    chk("ovf_COUT_spc2", 1, {63'b0, c1}, 64'd0);

    op(4'hC, 1'b0, 36'o123, 36'o456, 1'b0);
    repeat (11) @(posedge clk); #1;
    chk("ones_F", 0, {28'b0, f0}, 64'hFFFFFFFFF);

    op(4'h9, 1'b1, 36'o525252525252, 36'o777777000000, 1'b1);
    repeat (11) @(posedge clk); #1;
    chk("xor_F", 0, {28'b0, f0}, 64'o252525525252);
    chk("xor_COUT", 0, {63'b0, c0}, 64'd0);

    // Starts during RUN are ignored; a start in the done cycle is taken.
    op(4'h6, 1'b0, 36'd5, 36'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a_in = 36'd1; b_in = 36'd1; start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("ign_done_seen", 0, {63'b0, seen}, 64'd1);
    chk("ign_F", 0, {28'b0, f0}, 64'd8);
    s_in = 4'h6; m_in = 1'b0; a_in = 36'd2; b_in = 36'd2; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 0, {63'b0, busy0}, 64'd1);
    repeat (11) @(posedge clk); #1;
    chk("b2b_F", 0, {28'b0, f0}, 64'd4);

    // Reset in the middle of RUN.
    op(4'h6, 1'b0, 36'd100, 36'd23, 1'b0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 0, {63'b0, busy0}, 64'd0);
    chk("mid_rst_F", 0, {28'b0, f0}, 64'd0);
    chk("mid_rst_ZERO", 0, {63'b0, z0}, 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("mid_rst_no_done", 0, {63'b0, seen}, 64'd0);
    @(posedge clk); #1;

    // Randomized traffic: new inputs every cycle, frequent starts, rare resets.
    for (int i = 0; i < 4000; i++) begin
      s_in = 4'($urandom);
      m_in = 1'($urandom);
      a_in = {4'($urandom), 32'($urandom)};
      b_in = {4'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) a_in = 36'hFFFFFFFFF;
      cin_in = 1'($urandom);
      start = ($urandom_range(0, 9) < 4);
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
